// File: rtl/booth_pkg.sv
// booth_pkg: shared state/recode types and step-count helper for booth_seq_mult
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {NOP, ADD_M, SUB_M, ADD_2M, SUB_2M} op_t;

  // Number of recode/add/shift steps for one product
  function automatic int step_count(input int width, input bit radix4);
    return radix4 ? (width + 2) / 2 : width + 1;
  endfunction

endpackage

// File: rtl/booth_recode.sv
// booth_recode: Booth digit recoder, radix-4 triples when BOOTH_RADIX4_EN is defined, else radix-2 pairs
module booth_recode
  import booth_pkg::*;
(
`ifdef BOOTH_RADIX4_EN
  input  logic [2:0] i_bits,
`else
  input  logic [1:0] i_bits,
`endif
  output op_t        o_op
);

`ifdef BOOTH_RADIX4_EN
  // {q1, q0, q_m1} -> digit in {0, +-M, +-2M}
  always_comb
    case (i_bits)
      3'b001, 3'b010: o_op = ADD_M;
      3'b011:         o_op = ADD_2M;
      3'b100:         o_op = SUB_2M;
      3'b101, 3'b110: o_op = SUB_M;
      default:        o_op = NOP;
    endcase
`else
  // {q0, q_m1}: 10 starts a run of ones (subtract), 01 ends it (add)
  always_comb
    o_op = i_bits == 2'b10 ? SUB_M : i_bits == 2'b01 ? ADD_M : NOP;
`endif

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential Booth multiplier, signed/unsigned per operation; radix-4 when BOOTH_RADIX4_EN is defined
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
)(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_result
);

`ifdef BOOTH_RADIX4_EN
  localparam bit R4 = 1'b1;
`else
  localparam bit R4 = 1'b0;
`endif
  localparam int XW = R4 ? WIDTH + 2 : WIDTH + 1;
  localparam int SH = R4 ? 2 : 1;
  localparam int FW = 2 * XW + 1;
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(step_count(WIDTH, R4));

  generate
    if (WIDTH < 4) begin : g_bad_width
      $error("booth_seq_mult: WIDTH must be at least 4");
    end
    if (R4 && (WIDTH % 2 != 0)) begin : g_odd_width
      $error("booth_seq_mult: WIDTH must be even for radix-4");
    end
  endgenerate

  state_t           r_state;
  logic [XW-1:0]    r_a;
  logic [XW-1:0]    r_q;
  logic [XW-1:0]    r_m;
  logic             r_qm1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [2*WIDTH-1:0] r_result;

  op_t              w_op;
  logic [XW-1:0]    w_m2;
  logic [XW-1:0]    w_addend;
  logic [XW-1:0]    w_sum;
  logic [FW-1:0]    w_shift;
  logic [XW-1:0]    w_mx;
  logic [XW-1:0]    w_qx;

`ifdef BOOTH_RADIX4_EN
  logic [2:0] w_bits;
  assign w_bits = {r_q[1:0], r_qm1};
`else
  logic [1:0] w_bits;
  assign w_bits = {r_q[0], r_qm1};
`endif

  booth_recode u_recode (
    .i_bits (w_bits),
    .o_op   (w_op)
  );

  assign w_mx = {{(XW-WIDTH){i_signed & i_multiplicand[WIDTH-1]}}, i_multiplicand};
  assign w_qx = {{(XW-WIDTH){i_signed & i_multiplier[WIDTH-1]}}, i_multiplier};
  assign w_m2 = {r_m[XW-2:0], 1'b0};

  // select the partial-product term for the current Booth digit
  always_comb
    w_addend = w_op == ADD_M  ? r_m  :
               w_op == SUB_M  ? -r_m :
               w_op == ADD_2M ? w_m2 :
               w_op == SUB_2M ? -w_m2 : '0;

  assign w_sum   = r_a + w_addend;
  assign w_shift = $signed({w_sum, r_q, r_qm1}) >>> SH;

  // control FSM and datapath: load on an accepted start, one Booth step per RUN cycle
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (r_state == RUN) begin
      r_a   <= w_shift[FW-1 -: XW];
      r_q   <= w_shift[XW:1];
      r_qm1 <= w_shift[0];
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_state  <= DONE;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_result <= w_shift[2*WIDTH:1];
      end
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_state <= RUN;
        r_busy  <= 1'b1;
        r_a     <= '0;
        r_q     <= w_qx;
        r_m     <= w_mx;
        r_qm1   <= 1'b0;
        r_cnt   <= STEPS;
      end else begin
        r_state <= IDLE;
      end
    end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: scoreboard bench for booth_seq_mult at WIDTH=8 and WIDTH=32
module tb_booth_seq_mult;

`ifdef BOOTH_RADIX4_EN
  localparam bit R4 = 1'b1;
`else
  localparam bit R4 = 1'b0;
`endif
  localparam int L8  = R4 ? (8 + 2) / 2 : 8 + 1;
  localparam int L32 = R4 ? (32 + 2) / 2 : 32 + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic        busy8, done8;
  logic [15:0] res8;
  logic        s32 = 1'b0, sg32 = 1'b0;
  logic [31:0] m32 = '0, q32 = '0;
  logic        busy32, done32;
  logic [63:0] res32;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q8e[$];
  exp_t q32e[$];
  exp_t e8, e32;
  logic [15:0] last8 = '0;
  logic [63:0] last32 = '0;
  logic        prev8 = 1'b0, prev32 = 1'b0;

  booth_seq_mult #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8), .i_signed(sg8),
    .i_multiplicand(m8), .i_multiplier(q8),
    .o_busy(busy8), .o_done(done8), .o_result(res8)
  );

  booth_seq_mult #(.WIDTH(32)) u32 (
    .i_clk(clk), .i_rst(rst), .i_start(s32), .i_signed(sg32),
    .i_multiplicand(m32), .i_multiplier(q32),
    .o_busy(busy32), .o_done(done32), .o_result(res32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q, input bit s, input int w);
    logic [63:0] mx, qx, p;
    mx = {32'd0, m};
    qx = {32'd0, q};
    if (s && m[w-1]) mx = mx - (64'd1 << w);
    if (s && q[w-1]) qx = qx - (64'd1 << w);
    p = mx * qx;
    return (w == 32) ? p : p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // mode: 0 = start low during RUN, 1 = random dropped starts, 2 = start held high
  task automatic op8(input logic [7:0] m, input logic [7:0] q, input bit s, input int mode);
    @(negedge clk);
    s8 = 1'b1; m8 = m; q8 = q; sg8 = s;
    q8e.push_back('{ref_mul({24'd0, m}, {24'd0, q}, s, 8), cyc + 1 + L8});
    @(posedge clk);
    for (int i = 0; i < L8; i++) begin
      @(negedge clk);
      check("busy8_run", busy8, 1);
      s8 = mode == 2 ? 1'b1 : mode == 1 ? 1'($urandom) : 1'b0;
      m8 = 8'($urandom); q8 = 8'($urandom); sg8 = 1'($urandom);
    end
    if (mode != 2) s8 = 1'b0;
  endtask

  task automatic op32(input logic [31:0] m, input logic [31:0] q, input bit s, input int mode);
    @(negedge clk);
    s32 = 1'b1; m32 = m; q32 = q; sg32 = s;
    q32e.push_back('{ref_mul(m, q, s, 32), cyc + 1 + L32});
    @(posedge clk);
    for (int i = 0; i < L32; i++) begin
      @(negedge clk);
      check("busy32_run", busy32, 1);
      s32 = mode == 1 ? 1'($urandom) : 1'b0;
      m32 = $urandom; q32 = $urandom; sg32 = 1'($urandom);
    end
    s32 = 1'b0;
  endtask

  task automatic gap8(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s8 = 1'b0;
      check("busy8_idle", busy8, 0);
    end
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] ones;
    ones = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return ones;
      2: return 32'd1 << (w - 1);
      3: return 32'd1;
      default: return $urandom & ones;
    endcase
  endfunction

  // scoreboard monitor, WIDTH=8
  always @(negedge clk) begin
    if (done8) begin
      check("done8_pulse", prev8, 0);
      check("busy8_done", busy8, 0);
      if (q8e.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done8_unexpected actual=1 expected=0 result=%h", res8);
      end else begin
        e8 = q8e.pop_front();
        check("res8", {48'd0, res8}, e8.res);
        check("lat8", 64'(cyc), 64'(e8.at));
      end
    end else if (!rst) begin
      check("res8_hold", {48'd0, res8}, {48'd0, last8});
    end
    prev8 = done8;
    last8 = res8;
  end

  // scoreboard monitor, WIDTH=32
  always @(negedge clk) begin
    if (done32) begin
      check("done32_pulse", prev32, 0);
      if (q32e.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done32_unexpected actual=1 expected=0 result=%h", res32);
      end else begin
        e32 = q32e.pop_front();
        check("res32", res32, e32.res);
        check("lat32", 64'(cyc), 64'(e32.at));
      end
    end else if (!rst) begin
      check("res32_hold", res32, last32);
    end
    prev32 = done32;
    last32 = res32;
  end

  initial begin
    #12;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_res8", {48'd0, res8}, 64'd0);
    check("rst_res32", res32, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    gap8(2);
    check("idle_res8", {48'd0, res8}, 64'd0);
    check("idle_busy32", busy32, 0);

    op8(8'd7, 8'hFD, 1'b1, 0);
    gap8(1);
    op8(8'hFF, 8'hFF, 1'b0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 0);
    gap8(2);

    op8(8'h12, 8'h34, 1'b0, 2);
    op8(8'h80, 8'h80, 1'b1, 2);
    op8(8'h00, 8'h5A, 1'b1, 2);
    @(negedge clk);
    s8 = 1'b0;
    gap8(3);

    @(negedge clk);
    s8 = 1'b1; m8 = 8'h55; q8 = 8'h33; sg8 = 1'b0;
    @(posedge clk);
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy8", busy8, 0);
    check("abort_done8", done8, 0);
    check("abort_res8", {48'd0, res8}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    gap8(1);
    op8(8'h9C, 8'h27, 1'b1, 0);
    gap8(2);

    for (int n = 0; n < 2000; n++) begin
      op8(8'(pick(8)), 8'(pick(8)), 1'($urandom), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) gap8($urandom_range(1, 3));
    end
    gap8(2);

    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    op32(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 0);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
    for (int n = 0; n < 200; n++) begin
      op32(pick(32), pick(32), 1'($urandom), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        s32 = 1'b0;
      end
    end

    for (int i = 0; i < 200 && (q8e.size() != 0 || q32e.size() != 0); i++) @(negedge clk);
    check("drain_q8", 64'(q8e.size()), 64'd0);
    check("drain_q32", 64'(q32e.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
